// File: rtl/risc_pkg.sv
// Shared defaults, address-width helper and reset value for the RISC register file.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package risc_pkg;

  localparam int          DEF_DATA_W   = 8;
  localparam int          DEF_NUM_REGS = 8;
  localparam logic [63:0] REG_RST_VAL  = 64'h0;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_w(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  // True when an address names a real, writable register.
  // Out-of-range slots (non power-of-2 counts) and a hard-wired r0 are excluded.
  function automatic logic reg_valid(input int unsigned a, input int unsigned nregs,
                                     input logic zero_reg);
    return (a < nregs) && !(zero_reg && (a == 0));
  endfunction

endpackage

// File: rtl/risc_scoreboard.sv
// Pending-load scoreboard: one bit per register, popcount, duplicate-issue pulse, hazard flags.
// Latency: set/clear at the next edge; hazard is combinational and drops in the writeback cycle.
// Backpressure: none; hazards are advisory to the issue stage, which must stall on them.
module risc_scoreboard
  import risc_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_issue,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic              ld_wb_vld,
  input  logic [ADDR_W-1:0] ld_wb_dst,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              dup_issue
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_d;
  logic                issue_ok, wb_ok, dup_d;

  // Pending bit for an address; slots beyond NUM_REGS read as not pending.
  function automatic logic pend_at(input logic [NUM_REGS-1:0] v, input logic [ADDR_W-1:0] a);
    logic h;
    h = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (a == r[ADDR_W-1:0]) h = v[r];
    end
    return h;
  endfunction

  // Next pending vector: clear on writeback, then set on issue so a same-register issue wins.
  always_comb begin
    issue_ok = load_issue && reg_valid(32'(load_dst), NUM_REGS, ZERO_REG);
    wb_ok    = ld_wb_vld && reg_valid(32'(ld_wb_dst), NUM_REGS, ZERO_REG);
    pend_d   = pend_q;
    dup_d    = 1'b0;
    cnt_d    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wb_ok && (ld_wb_dst == r[ADDR_W-1:0])) pend_d[r] = 1'b0;
      if (issue_ok && (load_dst == r[ADDR_W-1:0])) begin
        dup_d     = pend_q[r];
        pend_d[r] = 1'b1;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
    end
  end

  // Operand hazards; a writeback to the same register in this cycle resolves it immediately.
  always_comb begin
    hazard_a = pend_at(pend_q, opnda_addr) & ~(ld_wb_vld && (ld_wb_dst == opnda_addr));
    hazard_b = pend_at(pend_q, opndb_addr) & ~(ld_wb_vld && (ld_wb_dst == opndb_addr));
  end

  // Scoreboard state, count and duplicate pulse all move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      pend_cnt  <= '0;
      dup_issue <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pend_cnt  <= cnt_d;
      dup_issue <= dup_d;
    end
  end

endmodule

// File: rtl/risc_regfile_sb.sv
// Register file with ALU and load write ports, bypassed read ports and pending-load scoreboard.
// Latency: reads 0 cycles (bypassed), writes stored at the next edge, pulses one cycle after cause.
// Backpressure: none; the issue stage stalls on hazard_a/hazard_b.
module risc_regfile_sb
  import risc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  output logic [DATA_W-1:0] oprnd_a,
  output logic [DATA_W-1:0] oprnd_b,
  output logic              hazard_a,
  output logic              hazard_b,
  input  logic              reg_wr_vld,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] rslt,
  input  logic              load_issue,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic              ld_wb_vld,
  input  logic [ADDR_W-1:0] ld_wb_dst,
  input  logic [DATA_W-1:0] dmdataout,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              wr_conflict,
  output logic              dup_issue
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wb_ok, alu_ok, conflict_d;

  // Read one port: invalid slots give zero, then load bypass, then ALU bypass, then storage.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (reg_valid(32'(a), NUM_REGS, ZERO_REG)) begin
      if (ld_wb_vld && (ld_wb_dst == a)) begin
        v = dmdataout;
      end else if (reg_wr_vld && (dst == a)) begin
        v = rslt;
      end else begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (a == r[ADDR_W-1:0]) v = mem_q[r];
        end
      end
    end
    return v;
  endfunction

  // Write qualification; a colliding ALU write loses to the load and is reported.
  always_comb begin
    wb_ok      = ld_wb_vld && reg_valid(32'(ld_wb_dst), NUM_REGS, ZERO_REG);
    alu_ok     = reg_wr_vld && reg_valid(32'(dst), NUM_REGS, ZERO_REG);
    conflict_d = wb_ok && alu_ok && (dst == ld_wb_dst);
  end

  // Bypassed combinational read ports.
  always_comb begin
    oprnd_a = rd_port(opnda_addr);
    oprnd_b = rd_port(opndb_addr);
  end

  // Register storage; load data has priority over ALU data on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= REG_RST_VAL[DATA_W-1:0];
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wb_ok && (ld_wb_dst == r[ADDR_W-1:0])) begin
          mem_q[r] <= dmdataout;
        end else if (alu_ok && (dst == r[ADDR_W-1:0])) begin
          mem_q[r] <= rslt;
        end
      end
    end
  end

  // One-cycle pulse after a same-register ALU/load collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_d;
  end

  risc_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .load_issue (load_issue),
    .load_dst   (load_dst),
    .ld_wb_vld  (ld_wb_vld),
    .ld_wb_dst  (ld_wb_dst),
    .opnda_addr (opnda_addr),
    .opndb_addr (opndb_addr),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
    .pend_cnt   (pend_cnt),
    .dup_issue  (dup_issue)
  );

endmodule

// File: tb/tb_risc_regfile_sb.sv
// Bench for risc_regfile_sb: three configurations driven in lockstep and checked every cycle.
// Instances: 8 regs with writable r0, 8 regs with hard-wired r0, 6 regs (out-of-range slots).
// A behavioural register/pending model predicts all outputs; literal checks pin the model.
module tb_risc_regfile_sb;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opnda, opndb, dst, load_dst, ld_wb_dst;
  logic       reg_wr_vld, load_issue, ld_wb_vld;
  logic [7:0] rslt, dm;

  logic [7:0] oa [NI];
  logic [7:0] ob [NI];
  logic       ha [NI];
  logic       hb [NI];
  logic       wc [NI];
  logic       di [NI];
  logic [3:0] pc [NI];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  risc_regfile_sb #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1'b0)) u0 (
    .clk(clk), .rst(rst), .opnda_addr(opnda), .opndb_addr(opndb),
    .oprnd_a(oa[0]), .oprnd_b(ob[0]), .hazard_a(ha[0]), .hazard_b(hb[0]),
    .reg_wr_vld(reg_wr_vld), .dst(dst), .rslt(rslt),
    .load_issue(load_issue), .load_dst(load_dst),
    .ld_wb_vld(ld_wb_vld), .ld_wb_dst(ld_wb_dst), .dmdataout(dm),
    .pend_cnt(pc[0]), .wr_conflict(wc[0]), .dup_issue(di[0]));

  risc_regfile_sb #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1'b1)) u1 (
    .clk(clk), .rst(rst), .opnda_addr(opnda), .opndb_addr(opndb),
    .oprnd_a(oa[1]), .oprnd_b(ob[1]), .hazard_a(ha[1]), .hazard_b(hb[1]),
    .reg_wr_vld(reg_wr_vld), .dst(dst), .rslt(rslt),
    .load_issue(load_issue), .load_dst(load_dst),
    .ld_wb_vld(ld_wb_vld), .ld_wb_dst(ld_wb_dst), .dmdataout(dm),
    .pend_cnt(pc[1]), .wr_conflict(wc[1]), .dup_issue(di[1]));

  risc_regfile_sb #(.DATA_W(8), .NUM_REGS(6), .ADDR_W(3), .ZERO_REG(1'b1)) u2 (
    .clk(clk), .rst(rst), .opnda_addr(opnda), .opndb_addr(opndb),
    .oprnd_a(oa[2]), .oprnd_b(ob[2]), .hazard_a(ha[2]), .hazard_b(hb[2]),
    .reg_wr_vld(reg_wr_vld), .dst(dst), .rslt(rslt),
    .load_issue(load_issue), .load_dst(load_dst),
    .ld_wb_vld(ld_wb_vld), .ld_wb_dst(ld_wb_dst), .dmdataout(dm),
    .pend_cnt(pc[2]), .wr_conflict(wc[2]), .dup_issue(di[2]));

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem  [NI][8];
  bit         m_pend [NI][8];
  bit         m_conf [NI];
  bit         m_dup  [NI];

  function automatic int nregs_of(int k);
    return (k == 2) ? 6 : 8;
  endfunction

  function automatic bit mvalid(int k, int a);
    return (a < nregs_of(k)) && !((k != 0) && (a == 0));
  endfunction

  function automatic logic [7:0] exp_rd(int k, logic [2:0] a);
    if (!mvalid(k, int'(a))) return 8'h00;
    if (ld_wb_vld && ld_wb_dst == a) return dm;
    if (reg_wr_vld && dst == a) return rslt;
    return m_mem[k][a];
  endfunction

  function automatic bit exp_hz(int k, logic [2:0] a);
    if (!mvalid(k, int'(a))) return 1'b0;
    return m_pend[k][a] && !(ld_wb_vld && ld_wb_dst == a);
  endfunction

  function automatic int exp_cnt(int k);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_pend[k][i]);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[k][i]  <= 8'h00;
          m_pend[k][i] <= 1'b0;
        end
        m_conf[k] <= 1'b0;
        m_dup[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        m_conf[k] <= reg_wr_vld && ld_wb_vld && (dst == ld_wb_dst) && mvalid(k, int'(dst));
        m_dup[k]  <= load_issue && mvalid(k, int'(load_dst)) && m_pend[k][load_dst];
        if (reg_wr_vld && mvalid(k, int'(dst)))       m_mem[k][dst]        <= rslt;
        if (ld_wb_vld && mvalid(k, int'(ld_wb_dst)))  m_mem[k][ld_wb_dst]  <= dm;
        if (ld_wb_vld && mvalid(k, int'(ld_wb_dst)))  m_pend[k][ld_wb_dst] <= 1'b0;
        if (load_issue && mvalid(k, int'(load_dst)))  m_pend[k][load_dst]  <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Compare every output of every instance against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("oprnd_a", k, 32'(oa[k]), 32'(exp_rd(k, opnda)));
        chk("oprnd_b", k, 32'(ob[k]), 32'(exp_rd(k, opndb)));
        chk("hazard_a", k, 32'(ha[k]), 32'(exp_hz(k, opnda)));
        chk("hazard_b", k, 32'(hb[k]), 32'(exp_hz(k, opndb)));
        chk("pend_cnt", k, 32'(pc[k]), 32'(exp_cnt(k)));
        chk("wr_conflict", k, 32'(wc[k]), 32'(m_conf[k]));
        chk("dup_issue", k, 32'(di[k]), 32'(m_dup[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    reg_wr_vld = 1'b0; load_issue = 1'b0; ld_wb_vld = 1'b0;
    dst = 3'd0; load_dst = 3'd0; ld_wb_dst = 3'd0; rslt = 8'h00; dm = 8'h00;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    opnda = 3'd0; opndb = 3'd0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    nxt(); rst = 1'b0;

    // Reset state: every address reads zero with no hazard.
    for (int a = 0; a < 8; a++) begin
      nxt(); opnda = 3'(a); opndb = 3'(7 - a);
      @(negedge clk);
      chk("rst_rd_a", 0, 32'(oa[0]), 32'h0);
      chk("rst_rd_b", 0, 32'(ob[0]), 32'h0);
      chk("rst_hz", 0, 32'(ha[0]), 32'h0);
      chk("rst_cnt", 0, 32'(pc[0]), 32'h0);
    end

    // ALU write with same-cycle bypass, then stored value.
    nxt(); idle(); reg_wr_vld = 1'b1; dst = 3'd2; rslt = 8'h22; opnda = 3'd2;
    @(negedge clk); chk("alu_bypass", 0, 32'(oa[0]), 32'h22);
    nxt(); idle();
    @(negedge clk); chk("alu_stored", 0, 32'(oa[0]), 32'h22);

    // Load issue, hazard, writeback clearing hazard in the same cycle.
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd5;
    nxt(); idle(); opnda = 3'd5;
    @(negedge clk); chk("ld_hazard", 0, 32'(ha[0]), 32'h1); chk("ld_cnt1", 0, 32'(pc[0]), 32'h1);
    nxt(); idle(); ld_wb_vld = 1'b1; ld_wb_dst = 3'd5; dm = 8'h55;
    @(negedge clk); chk("wb_hazard", 0, 32'(ha[0]), 32'h0); chk("wb_bypass", 0, 32'(oa[0]), 32'h55);
    nxt(); idle();
    @(negedge clk); chk("wb_cnt0", 0, 32'(pc[0]), 32'h0); chk("wb_stored", 0, 32'(oa[0]), 32'h55);

    // ALU and load collide on r3: load data wins, conflict pulses once.
    nxt(); idle(); reg_wr_vld = 1'b1; dst = 3'd3; rslt = 8'hAA;
    ld_wb_vld = 1'b1; ld_wb_dst = 3'd3; dm = 8'h33; opnda = 3'd3;
    @(negedge clk); chk("coll_bypass", 0, 32'(oa[0]), 32'h33); chk("coll_pre", 0, 32'(wc[0]), 32'h0);
    nxt(); idle();
    @(negedge clk); chk("coll_stored", 0, 32'(oa[0]), 32'h33); chk("coll_pulse", 0, 32'(wc[0]), 32'h1);
    nxt(); idle();
    @(negedge clk); chk("coll_post", 0, 32'(wc[0]), 32'h0);

    // Hard-wired r0: write and issue are ignored.
    nxt(); idle(); reg_wr_vld = 1'b1; dst = 3'd0; rslt = 8'h7F;
    load_issue = 1'b1; load_dst = 3'd0; opnda = 3'd0;
    @(negedge clk); chk("z_rd", 1, 32'(oa[1]), 32'h0); chk("z_hz", 1, 32'(ha[1]), 32'h0);
    chk("nz_bypass", 0, 32'(oa[0]), 32'h7F);
    nxt(); idle();
    @(negedge clk);
    chk("z_rd2", 1, 32'(oa[1]), 32'h0); chk("z_hz2", 1, 32'(ha[1]), 32'h0);
    chk("z_cnt", 1, 32'(pc[1]), 32'h0); chk("z_dup", 1, 32'(di[1]), 32'h0);
    chk("z_conf", 1, 32'(wc[1]), 32'h0);
    chk("nz_hz", 0, 32'(ha[0]), 32'h1); chk("nz_cnt", 0, 32'(pc[0]), 32'h1);

    // Loads to 1,4,6 then reset mid-stream.
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd1;
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd4;
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd6;
    nxt(); idle();
    @(negedge clk); chk("multi_cnt", 1, 32'(pc[1]), 32'h3); chk("multi_cnt", 0, 32'(pc[0]), 32'h4);
    chk("multi_cnt", 2, 32'(pc[2]), 32'h2);
    nxt(); idle(); rst = 1'b1; opnda = 3'd2;
    @(negedge clk); chk("mrst_cnt", 0, 32'(pc[0]), 32'h0); chk("mrst_rd", 0, 32'(oa[0]), 32'h0);
    for (int a = 0; a < 8; a++) begin
      nxt(); opnda = 3'(a);
      @(negedge clk); chk("mrst_rd_all", 0, 32'(oa[0]), 32'h0);
    end
    nxt(); rst = 1'b0;

    // Duplicate issue to r4 pulses exactly once.
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd4;
    @(negedge clk); chk("dup_first", 0, 32'(di[0]), 32'h0);
    nxt(); idle(); load_issue = 1'b1; load_dst = 3'd4;
    @(negedge clk); chk("dup_second", 0, 32'(di[0]), 32'h0);
    nxt(); idle();
    @(negedge clk); chk("dup_pulse", 0, 32'(di[0]), 32'h1); chk("dup_cnt", 0, 32'(pc[0]), 32'h1);
    nxt(); idle();
    @(negedge clk); chk("dup_post", 0, 32'(di[0]), 32'h0);

    // Writeback to a register forgotten by reset still writes.
    nxt(); idle(); ld_wb_vld = 1'b1; ld_wb_dst = 3'd1; dm = 8'h11;
    nxt(); idle(); opnda = 3'd1;
    @(negedge clk); chk("stale_wb", 0, 32'(oa[0]), 32'h11); chk("stale_hz", 0, 32'(ha[0]), 32'h0);

    // Out-of-range slot on the 6-register instance.
    nxt(); idle(); reg_wr_vld = 1'b1; dst = 3'd7; rslt = 8'h77; opnda = 3'd7;
    @(negedge clk); chk("oor_rd", 2, 32'(oa[2]), 32'h0); chk("in_rng_rd", 0, 32'(oa[0]), 32'h77);
    nxt(); idle();
    @(negedge clk); chk("oor_rd2", 2, 32'(oa[2]), 32'h0);

    // Randomized traffic with small address space to force collisions and duplicates.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst        = ($urandom_range(0, 79) == 0);
      opnda      = 3'($urandom_range(0, 7));
      opndb      = 3'($urandom_range(0, 7));
      reg_wr_vld = 1'($urandom_range(0, 1));
      dst        = 3'($urandom_range(0, 7));
      rslt       = 8'($urandom);
      load_issue = ($urandom_range(0, 2) == 0);
      load_dst   = 3'($urandom_range(0, 7));
      ld_wb_vld  = ($urandom_range(0, 2) == 0);
      ld_wb_dst  = 3'($urandom_range(0, 7));
      dm         = 8'($urandom);
    end
    nxt(); idle(); rst = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
